// File: rtl/run_det_pkg.sv
// Shared definitions for the run detector.
// - state_e   : FSM state encoding (IDLE/RUN/HIT)
// - thr_clamp : maps the raw threshold input onto the supported range 1..max_run
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10
  } state_e;

  // A zero threshold behaves as 1; anything above max_run is capped at max_run.
  function automatic int unsigned thr_clamp(input int unsigned thr,
                                            input int unsigned max_run);
    if (thr == 0) begin
      return 1;
    end else if (thr > max_run) begin
      return max_run;
    end else begin
      return thr;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-1.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (count -> 0)
//   clr   - synchronous clear (highest priority after reset)
//   load  - synchronous load of the value 1
//   inc   - increment by one, holding at MAX
//   q     - current count
module sat_counter #(
  parameter int unsigned W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = W'(1);
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/run_detector_n.sv
// Detects runs of a programmable number of consecutive bits equal to
// `target`, in overlapping or non-overlapping mode, and counts detections.
// Ports:
//   clk, reset    - rising-edge clock, asynchronous active-low reset
//   enable        - sample data_in this cycle; otherwise all state holds
//   clear         - synchronous clear of run state, outputs and det_count
//   data_in       - serial input bit
//   target        - polarity of the run to detect (1 = ones, 0 = zeros)
//   overlap       - 1 = overlapping detection, 0 = non-overlapping
//   threshold     - requested run length (clamped to 1..MAX_RUN)
//   detect        - high while in HIT
//   det_pulse     - one-cycle strobe per entry into HIT
//   run_len       - current matching run length, saturating at MAX_RUN
//   det_count     - saturating detection count
module run_detector_n
  import run_det_pkg::*;
#(
  parameter  int unsigned MAX_RUN = 7,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned CW      = $clog2(MAX_RUN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             data_in,
  input  logic             target,
  input  logic             overlap,
  input  logic [CW-1:0]    threshold,
  output logic             detect,
  output logic             det_pulse,
  output logic [CW-1:0]    run_len,
  output logic [CNT_W-1:0] det_count
);

  state_e          state_q, state_d;
  logic            det_pulse_q, det_pulse_d;
  logic [CW-1:0]   thr_eff;
  logic [CW-1:0]   run_len_w;
  logic            match;
  logic            next_reaches_thr;
  logic            hit_entry;
  logic            run_clr, run_load, run_inc;

  assign thr_eff = CW'(thr_clamp(32'(threshold), MAX_RUN));
  assign match   = (data_in == target);

  // Compared one bit wider so run_len + 1 cannot wrap. Using >= (not ==)
  // also resolves a threshold lowered below the current run length.
  assign next_reaches_thr = ((CW + 1)'(run_len_w) + (CW + 1)'(1)) >= (CW + 1)'(thr_eff);

  // State memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      det_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      det_pulse_q <= det_pulse_d;
    end
  end

  // Next-state logic; also drives the run-length counter controls
  always_comb begin
    state_d   = state_q;
    hit_entry = 1'b0;
    run_clr   = clear;
    run_load  = 1'b0;
    run_inc   = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if (match) begin
            run_load = 1'b1;
            if (thr_eff == CW'(1)) begin
              state_d   = HIT;
              hit_entry = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (match) begin
            run_inc = 1'b1;
            if (next_reaches_thr) begin
              state_d   = HIT;
              hit_entry = 1'b1;
            end
          end else begin
            state_d = IDLE;
            run_clr = 1'b1;
          end
        end
        HIT: begin
          if (!match) begin
            state_d = IDLE;
            run_clr = 1'b1;
          end else if (overlap) begin
            run_inc = 1'b1;
          end else begin
            // Non-overlapping: the matching bit starts a fresh run.
            run_load = 1'b1;
            if (thr_eff == CW'(1)) begin
              hit_entry = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        default: begin
          state_d = IDLE;
          run_clr = 1'b1;
        end
      endcase
    end
    det_pulse_d = hit_entry;
  end

  // Output decode
  always_comb begin
    detect = (state_q == HIT);
  end

  assign det_pulse = det_pulse_q;
  assign run_len   = run_len_w;

  sat_counter #(
    .W   (CW),
    .MAX (CW'(MAX_RUN))
  ) u_run_len (
    .clk   (clk),
    .reset (reset),
    .clr   (run_clr),
    .load  (run_load),
    .inc   (run_inc),
    .q     (run_len_w)
  );

  // Counts on the same edge that enters HIT, so the increment is visible
  // together with detect and det_pulse.
  sat_counter #(
    .W (CNT_W)
  ) u_det_count (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .load  (1'b0),
    .inc   (hit_entry),
    .q     (det_count)
  );

endmodule
